frame_write_ctrl: RTL

FRAME_WRITE_CTRL -- requirements
Module: frame_write_ctrl

---
 rtl/frame_write_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/frame_write_ctrl.sv
// frame_write_ctrl
// Moves camera pixels from a show-ahead FIFO into one of two DDR frame buffers
// as fixed-size write bursts. Completed frames flip the buffers so a display
// reader can always use the most recently finished one.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   frame_start         : one-cycle vsync pulse (already in clk domain)
//   fifo_rdusedw/_q     : FIFO fill level and head word (show-ahead)
//   fifo_rdreq          : FIFO read strobe, mirrors accepted data beats
//   wr_burst_*          : burst request/length/address/data towards DDR controller
//   wr_burst_data_req   : controller consumes wr_burst_data this cycle
//   wr_burst_finish     : controller reports burst complete
//   frame_done          : one-cycle pulse, whole frame written
//   frame_err           : one-cycle pulse, frame aborted by an early frame_start
//   rd_buf              : index of the last completed buffer
module frame_write_ctrl #(
    parameter int          BURST_LEN   = 64,
    parameter int          FRAME_WORDS = 153600,
    parameter logic [27:0] BUF0_BASE   = 28'h000_0000,
    parameter logic [27:0] BUF1_BASE   = 28'h080_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [10:0] fifo_rdusedw,
    output logic        fifo_rdreq,
    input  logic [31:0] fifo_q,
    output logic        wr_burst_req,
    output logic [9:0]  wr_burst_len,
    output logic [27:0] wr_burst_addr,
    input  logic        wr_burst_data_req,
    output logic [31:0] wr_burst_data,
    input  logic        wr_burst_finish,
    output logic        frame_done,
    output logic        rd_buf,
    output logic        frame_err
);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, REQ, WRITE, DONE} state_t;

    localparam logic [17:0] FRAME_WORDS_W = 18'(FRAME_WORDS);
    localparam logic [17:0] BURST_LEN_W   = 18'(BURST_LEN);

    state_t      state_q, state_d;
    logic [17:0] word_cnt_q, word_cnt_d;
    logic [27:0] addr_q, addr_d;
    logic [9:0]  wr_burst_len_q, wr_burst_len_d;
    logic [27:0] wr_burst_addr_q, wr_burst_addr_d;
    logic        wr_burst_req_q, wr_burst_req_d;
    logic [9:0]  beat_cnt_q, beat_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;
    logic        wr_buf_q, wr_buf_d;
    logic        rd_buf_q, rd_buf_d;
    logic        start_pend_q, start_pend_d;

    logic [17:0] remaining;
    logic [9:0]  next_len;
    logic [17:0] cnt_after;
    logic [27:0] addr_after;
    logic [27:0] wr_base;
    logic        in_burst;

    // Beats past the latched burst length are not forwarded to the FIFO, so a
    // controller that over-requests cannot drain words belonging to the next burst.
    assign in_burst      = (state_q == REQ) || (state_q == WRITE);
    assign fifo_rdreq    = in_burst && wr_burst_data_req && (beat_cnt_q < wr_burst_len_q);
    assign wr_burst_data = fifo_q;

    assign wr_burst_req  = wr_burst_req_q;
    assign wr_burst_len  = wr_burst_len_q;
    assign wr_burst_addr = wr_burst_addr_q;
    assign frame_done    = frame_done_q;
    assign frame_err     = frame_err_q;
    assign rd_buf        = rd_buf_q;

    always_comb begin
        remaining  = FRAME_WORDS_W - word_cnt_q;
        next_len   = (remaining < BURST_LEN_W) ? remaining[9:0] : BURST_LEN_W[9:0];
        cnt_after  = word_cnt_q + {8'd0, wr_burst_len_q};
        addr_after = addr_q + {16'd0, wr_burst_len_q, 2'b00};
        wr_base    = wr_buf_q ? BUF1_BASE : BUF0_BASE;

        state_d         = state_q;
        word_cnt_d      = word_cnt_q;
        addr_d          = addr_q;
        wr_burst_len_d  = wr_burst_len_q;
        wr_burst_addr_d = wr_burst_addr_q;
        wr_burst_req_d  = wr_burst_req_q;
        beat_cnt_d      = fifo_rdreq ? beat_cnt_q + 10'd1 : beat_cnt_q;
        frame_done_d    = 1'b0;
        frame_err_d     = 1'b0;
        wr_buf_d        = wr_buf_q;
        rd_buf_d        = rd_buf_q;
        start_pend_d    = start_pend_q;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d    = WAIT_DATA;
                    word_cnt_d = 18'd0;
                    addr_d     = wr_base;
                end
            end
            WAIT_DATA: begin
                // A new vsync wins over launching a burst; only a partially
                // written frame counts as an error.
                if (frame_start) begin
                    frame_err_d = (word_cnt_q != 18'd0);
                    word_cnt_d  = 18'd0;
                    addr_d      = wr_base;
                end else if ({1'b0, next_len} <= fifo_rdusedw) begin
                    state_d         = REQ;
                    wr_burst_len_d  = next_len;
                    wr_burst_addr_d = addr_q;
                    wr_burst_req_d  = 1'b1;
                    beat_cnt_d      = 10'd0;
                end
            end
            REQ: begin
                if (frame_start) begin
                    start_pend_d = 1'b1;
                end
                if (wr_burst_data_req) begin
                    wr_burst_req_d = 1'b0;
                    state_d        = WRITE;
                end
            end
            WRITE: begin
                if (frame_start) begin
                    start_pend_d = 1'b1;
                end
                if (wr_burst_finish) begin
                    start_pend_d = 1'b0;
                    if (start_pend_q || frame_start) begin
                        // Burst in flight was allowed to finish; now restart
                        // the same buffer from its base.
                        frame_err_d = 1'b1;
                        word_cnt_d  = 18'd0;
                        addr_d      = wr_base;
                        state_d     = WAIT_DATA;
                    end else if (cnt_after >= FRAME_WORDS_W) begin
                        // Buffer swap is done on entry so DONE already sees the
                        // buffer the next frame must use.
                        word_cnt_d   = cnt_after;
                        addr_d       = addr_after;
                        frame_done_d = 1'b1;
                        rd_buf_d     = wr_buf_q;
                        wr_buf_d     = ~wr_buf_q;
                        state_d      = DONE;
                    end else begin
                        word_cnt_d = cnt_after;
                        addr_d     = addr_after;
                        state_d    = WAIT_DATA;
                    end
                end
            end
            DONE: begin
                if (frame_start) begin
                    state_d    = WAIT_DATA;
                    word_cnt_d = 18'd0;
                    addr_d     = wr_base;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            word_cnt_q      <= 18'd0;
            addr_q          <= 28'd0;
            wr_burst_len_q  <= 10'd0;
            wr_burst_addr_q <= 28'd0;
            wr_burst_req_q  <= 1'b0;
            beat_cnt_q      <= 10'd0;
            frame_done_q    <= 1'b0;
            frame_err_q     <= 1'b0;
            wr_buf_q        <= 1'b0;
            rd_buf_q        <= 1'b1;
            start_pend_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_cnt_q      <= word_cnt_d;
            addr_q          <= addr_d;
            wr_burst_len_q  <= wr_burst_len_d;
            wr_burst_addr_q <= wr_burst_addr_d;
            wr_burst_req_q  <= wr_burst_req_d;
            beat_cnt_q      <= beat_cnt_d;
            frame_done_q    <= frame_done_d;
            frame_err_q     <= frame_err_d;
            wr_buf_q        <= wr_buf_d;
            rd_buf_q        <= rd_buf_d;
            start_pend_q    <= start_pend_d;
        end
    end

endmodule
